ppc_pipe_adder: RTL and testbench
=================================

Name: ppc_pipe_adder

Overview:
- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor.
- Operates on kill/propagate/generate (K/P/G) carry status with one register per prefix level.
- Carries a valid/ready handshake and a global stall.
- Next-generation replacement for the combinational 64-position prefix-carry network; sits in the datapath feeding the Wallace multiplier's final carry-propagate addition.

Parameters:
- WIDTH, 64, operand width; power of two, 2..128.
- LEVELS, log2(WIDTH), number of prefix levels; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in; ignored when in_sub=1
- in_sub  input  1  1 = compute A-B, 0 = A+B+cin
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_sum  output  WIDTH  result
- out_cout  output  1  carry out of bit WIDTH-1; for subtract, 1 means no borrow
- out_ovf  output  1  signed two's-complement overflow
- out_zero  output  1  out_sum == 0

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state changes on the rising edge of clk.
- Reset:
  - All stage valid bits are cleared.
  - out_valid, out_sum, out_cout, out_ovf and out_zero are 0 one edge after rst is sampled high.
  - in_ready is combinational and reads 1 during and after reset.
- Reset mid-operation: all in-flight beats are discarded; no partial result ever appears.
- Handshake:
  - A beat is accepted on an edge where in_valid && in_ready.
  - A result transfers on an edge where out_valid && out_ready.
- Stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stall=1 every pipeline register, including all valid bits, holds. out_* hold stable.
  - Bubbles are not collapsed.
- Stage 0 (captured on the accept edge):
  - b' = in_sub ? ~in_b : in_b; c0 = in_sub ? 1 : in_cin.
  - Per bit i: p_i = a_i ^ b'_i; g_i = a_i & b'_i.
  - Bit 0 folds in the carry: g_0 |= p_0 & c0.
  - Each bit's status is encoded as a 2-bit K/P/G symbol: K=00, P=01, G=10; 11 is illegal and never generated.
  - Stage 0 registers the p vector, the status vector, and the operand MSBs a_msb and b'_msb.
- Prefix level j = 1..LEVELS (one register each), distance d = 2^(j-1):
  - For i >= d: status[i] = K if status[i]==K; G if status[i]==G; otherwise (status[i]==P) status[i-d].
  - For i < d: status[i] passes unchanged.
  - p, a_msb and b'_msb travel alongside.
- Output register:
  - Carry into bit i: c_i = (status[i-1]==G) for i >= 1; c_0 = c0.
  - c0 is piped as a 1-bit signal.
  - sum_i = p_i ^ c_i.
  - cout = (status[WIDTH-1]==G).
  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb).
  - zero = ~|sum.
- Latency: a beat accepted on edge k has out_valid=1 after edge k+LEVELS+1 when there is no stall. WIDTH=64 gives 7 cycles.
- Throughput: one beat per cycle when out_ready is held at 1.
- Simultaneous accept and transfer in the same cycle is legal and is the normal streaming case.
- Wrap-around: the sum is modulo 2^WIDTH; the carry appears only on out_cout.
- Status propagation never depends on bits above i, so results are independent of WIDTH padding.

Test Plan:
- Reset: assert rst for 2 cycles while in_valid=1 with data. Required: out_valid=0, all out_*=0, and no result emerges in the 10 cycles after rst drops with in_valid=0.
- Full carry chain, WIDTH=64: A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1. Required after 7 cycles: sum=0, cout=1, zero=1, ovf=0.
- Subtract and overflow: A=0x8000_0000_0000_0000, B=1, sub=1. Required: sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1. Then A=3, B=5, sub=1. Required: sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- Streaming: 100 back-to-back random beats with out_ready=1. Required: results in order, one per cycle, each matching a reference model A+B+cin or A-B.
- Backpressure: stream 20 beats while toggling out_ready pseudo-randomly. Required: out_* stable while stalled, in_ready == !(out_valid && !out_ready), no beat lost or duplicated.
- Parameter sweep: WIDTH=2, 8 and 128, exhaustive for WIDTH=2 (all a, b, cin, sub). Required: latency LEVELS+1 and all results match the reference model.

Source files
------------

// File: rtl/ppc_pipe_adder.sv
// Pipelined Kogge-Stone adder/subtractor: stage 0 encodes per-bit K/P/G status,
// LEVELS prefix registers resolve carries, and an output register forms sum and flags.
module ppc_pipe_adder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int LEVELS = $clog2(WIDTH);

  localparam logic [1:0] KPG_K = 2'b00;
  localparam logic [1:0] KPG_P = 2'b01;
  localparam logic [1:0] KPG_G = 2'b10;

  if (WIDTH < 2 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("ppc_pipe_adder: WIDTH must be a power of two in 2..128");
  end

  // Per-bit status symbol: generate wins over propagate, otherwise kill.
  function automatic logic [2*WIDTH-1:0] kpg_encode(input logic [WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0] g);
    logic [2*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (g[i])      r[2*i +: 2] = KPG_G;
      else if (p[i]) r[2*i +: 2] = KPG_P;
      else           r[2*i +: 2] = KPG_K;
    end
    return r;
  endfunction

  // One Kogge-Stone level: a propagating position inherits the status d bits below.
  function automatic logic [2*WIDTH-1:0] kpg_level(input logic [2*WIDTH-1:0] s,
                                                   input int d);
    logic [2*WIDTH-1:0] r;
    int src;
    r = s;
    for (int i = 0; i < WIDTH; i++) begin
      src = (i >= d) ? i - d : i;
      if (i >= d && s[2*i +: 2] == KPG_P) r[2*i +: 2] = s[2*src +: 2];
    end
    return r;
  endfunction

  logic                          stall;
  logic [LEVELS:0]               vld_pn;
  logic [LEVELS:0][2*WIDTH-1:0]  stat_pn;
  logic [LEVELS:0][WIDTH-1:0]    p_pn;
  logic [LEVELS:0]               c0_pn;
  logic [LEVELS:0]               a_msb_pn;
  logic [LEVELS:0]               b_msb_pn;

  logic [LEVELS:0][2*WIDTH-1:0]  stat_nx;
  logic [WIDTH-1:0]              b_eff;
  logic [WIDTH-1:0]              p_in;
  logic [WIDTH-1:0]              g_in;
  logic                          c0_in;

  logic [2*WIDTH-1:0]            stat_last;
  logic [WIDTH-1:0]              carry;
  logic [WIDTH-1:0]              sum_nx;
  logic                          cout_nx;
  logic                          ovf_nx;
  logic                          zero_nx;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Stage 0 encode and prefix-level combine
  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    c0_in   = in_sub ? 1'b1 : in_cin;
    p_in    = in_a ^ b_eff;
    g_in    = in_a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c0_in);
    stat_nx = '0;
    stat_nx[0] = kpg_encode(p_in, g_in);
    for (int j = 1; j <= LEVELS; j++) begin
      stat_nx[j] = kpg_level(stat_pn[j-1], 1 << (j - 1));
    end
  end

  // Output stage: carries come straight from the resolved status of the bit below
  always_comb begin
    stat_last = stat_pn[LEVELS];
    carry     = '0;
    carry[0]  = c0_pn[LEVELS];
    for (int i = 1; i < WIDTH; i++) begin
      carry[i] = (stat_last[2*(i-1) +: 2] == KPG_G);
    end
    sum_nx  = p_pn[LEVELS] ^ carry;
    cout_nx = (stat_last[2*WIDTH-1 -: 2] == KPG_G);
    ovf_nx  = (a_msb_pn[LEVELS] == b_msb_pn[LEVELS]) && (sum_nx[WIDTH-1] != a_msb_pn[LEVELS]);
    zero_nx = ~|sum_nx;
  end

  // Control and result registers; result data only loads from a valid beat
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pn    <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (!stall) begin
      vld_pn    <= {vld_pn[LEVELS-1:0], in_valid};
      out_valid <= vld_pn[LEVELS];
      if (vld_pn[LEVELS]) begin
        out_sum  <= sum_nx;
        out_cout <= cout_nx;
        out_ovf  <= ovf_nx;
        out_zero <= zero_nx;
      end
    end
  end

  // Datapath registers: stage 0 capture, then one register per prefix level
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (in_valid) begin
        stat_pn[0]  <= stat_nx[0];
        p_pn[0]     <= p_in;
        c0_pn[0]    <= c0_in;
        a_msb_pn[0] <= in_a[WIDTH-1];
        b_msb_pn[0] <= b_eff[WIDTH-1];
      end
      for (int j = 1; j <= LEVELS; j++) begin
        stat_pn[j]  <= stat_nx[j];
        p_pn[j]     <= p_pn[j-1];
        c0_pn[j]    <= c0_pn[j-1];
        a_msb_pn[j] <= a_msb_pn[j-1];
        b_msb_pn[j] <= b_msb_pn[j-1];
      end
    end
  end

endmodule

// File: tb/tb_ppc_pipe_adder.sv
// Bench for ppc_pipe_adder: WIDTH=64 main instance plus WIDTH=2/8/128 sweep instances,
// all checked against a plain-arithmetic reference in one negedge compare process.
module tb_ppc_pipe_adder;
  localparam int W      = 64;
  localparam int LAT    = 7;
  localparam int LAT2   = 2;
  localparam int LAT8   = 4;
  localparam int LAT128 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0]  in_a, in_b;
  logic          out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [W-1:0]  out_sum;

  logic [127:0]  sw_a, sw_b;
  logic          sw_cin, sw_sub, sw_valid, sw_ready;
  logic          r2, r8, r128;
  logic          o2_valid, o2_cout, o2_ovf, o2_zero;
  logic          o8_valid, o8_cout, o8_ovf, o8_zero;
  logic          o128_valid, o128_cout, o128_ovf, o128_zero;
  logic [1:0]    o2_sum;
  logic [7:0]    o8_sum;
  logic [127:0]  o128_sum;

  ppc_pipe_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero));

  ppc_pipe_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r2),
    .in_a(sw_a[1:0]), .in_b(sw_b[1:0]), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(o2_valid), .out_ready(sw_ready), .out_sum(o2_sum),
    .out_cout(o2_cout), .out_ovf(o2_ovf), .out_zero(o2_zero));

  ppc_pipe_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r8),
    .in_a(sw_a[7:0]), .in_b(sw_b[7:0]), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(o8_valid), .out_ready(sw_ready), .out_sum(o8_sum),
    .out_cout(o8_cout), .out_ovf(o8_ovf), .out_zero(o8_zero));

  ppc_pipe_adder #(.WIDTH(128)) dut128 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r128),
    .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(o128_valid), .out_ready(sw_ready), .out_sum(o128_sum),
    .out_cout(o128_cout), .out_ovf(o128_ovf), .out_zero(o128_zero));

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         cin;
    logic         sub;
    int           acc;
    int           stalls;
    logic         lit_en;
    logic [130:0] lit;
  } beat_t;

  beat_t q[$];
  beat_t sq2[$];
  beat_t sq8[$];
  beat_t sq128[$];

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           stall_cnt = 0;
  logic         bp_on = 1'b0;
  logic         fin_req = 1'b0;
  logic         fin_done = 1'b0;
  logic         cur_lit_en = 1'b0;
  logic [130:0] cur_lit = '0;
  logic         prev_rst = 1'b0;
  logic         prev_stall = 1'b0;
  logic [67:0]  prev_out = '0;
  beat_t        bt;
  beat_t        nb;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain (w+1)-bit addition of a, b or ~b, and carry-in.
  // Result packed as {sum[127:0], cout, ovf, zero}.
  function automatic logic [130:0] model(input int w, input logic [127:0] a, input logic [127:0] b,
                                         input logic cin, input logic sub);
    logic [127:0] mask, am, bb, s;
    logic [128:0] t;
    logic         c, ovf;
    mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
    am   = a & mask;
    bb   = (sub ? ~b : b) & mask;
    c    = sub ? 1'b1 : cin;
    t    = {1'b0, am} + {1'b0, bb} + {128'd0, c};
    s    = t[127:0] & mask;
    ovf  = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
    return {s, t[w], ovf, (s == 128'd0)};
  endfunction

  task automatic chk(input string nm, input logic [130:0] got, input logic [130:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic spurious(input string nm);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d: got=result_valid exp=no_pending_beat", nm, cyc);
  endtask

  task automatic sw_cmp(input string nm, input int w, input int lat, input beat_t b,
                        input logic [130:0] got);
    chk(nm, got, model(w, b.a, b.b, b.cin, b.sub));
    chk({nm, "_latency"}, 131'(cyc), 131'(b.acc + lat));
  endtask

  // Single compare process, sampled on the falling edge
  always @(negedge clk) begin
    if (prev_rst) begin
      chk("reset_outputs", {63'd0, out_valid, out_sum, out_cout, out_ovf, out_zero}, '0);
      chk("reset_in_ready", {130'd0, in_ready}, 131'd1);
      chk("reset_sweep_valid", {128'd0, o2_valid, o8_valid, o128_valid}, '0);
    end
    if (rst) begin
      q.delete();
      sq2.delete();
      sq8.delete();
      sq128.delete();
    end else if (cyc > 0) begin
      chk("in_ready_rule", {130'd0, in_ready}, {130'd0, !(out_valid && !out_ready)});
      if (prev_stall)
        chk("stall_hold", {63'd0, out_valid, out_sum, out_cout, out_ovf, out_zero}, {63'd0, prev_out});
      if (out_valid && q.size() == 0) spurious("main_spurious");
      else if (out_valid && out_ready) begin
        bt = q.pop_front();
        chk("main_result", {64'd0, out_sum, out_cout, out_ovf, out_zero},
            model(W, bt.a, bt.b, bt.cin, bt.sub));
        if (bt.lit_en)
          chk("main_literal", {64'd0, out_sum, out_cout, out_ovf, out_zero}, bt.lit);
        if (bt.stalls == stall_cnt)
          chk("main_latency", 131'(cyc), 131'(bt.acc + LAT));
      end
      if (o2_valid) begin
        if (sq2.size() == 0) spurious("w2_spurious");
        else begin
          bt = sq2.pop_front();
          sw_cmp("w2_result", 2, LAT2, bt, {126'd0, o2_sum, o2_cout, o2_ovf, o2_zero});
        end
      end
      if (o8_valid) begin
        if (sq8.size() == 0) spurious("w8_spurious");
        else begin
          bt = sq8.pop_front();
          sw_cmp("w8_result", 8, LAT8, bt, {120'd0, o8_sum, o8_cout, o8_ovf, o8_zero});
        end
      end
      if (o128_valid) begin
        if (sq128.size() == 0) spurious("w128_spurious");
        else begin
          bt = sq128.pop_front();
          sw_cmp("w128_result", 128, LAT128, bt, {o128_sum, o128_cout, o128_ovf, o128_zero});
        end
      end
      if (out_valid && !out_ready) stall_cnt++;
      if (in_valid && in_ready) begin
        nb.a = {64'd0, in_a};
        nb.b = {64'd0, in_b};
        nb.cin = in_cin;
        nb.sub = in_sub;
        nb.acc = cyc + 1;
        nb.stalls = stall_cnt;
        nb.lit_en = cur_lit_en;
        nb.lit = cur_lit;
        q.push_back(nb);
      end
      nb.a = sw_a;
      nb.b = sw_b;
      nb.cin = sw_cin;
      nb.sub = sw_sub;
      nb.acc = cyc + 1;
      nb.stalls = 0;
      nb.lit_en = 1'b0;
      nb.lit = '0;
      if (sw_valid && r2)   sq2.push_back(nb);
      if (sw_valid && r8)   sq8.push_back(nb);
      if (sw_valid && r128) sq128.push_back(nb);
    end
    if (fin_req && !fin_done) begin
      chk("main_all_drained", 131'(q.size()), '0);
      chk("w2_all_drained", 131'(sq2.size()), '0);
      chk("w8_all_drained", 131'(sq8.size()), '0);
      chk("w128_all_drained", 131'(sq128.size()), '0);
      fin_done = 1'b1;
    end
    prev_rst   = rst;
    prev_stall = (cyc > 0) && !rst && out_valid && !out_ready;
    prev_out   = {out_valid, out_sum, out_cout, out_ovf, out_zero};
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic cin,
                      input logic sub, input logic le, input logic [130:0] lit);
    logic ok;
    int   tries;
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    cur_lit_en = le; cur_lit = lit;
    in_valid = 1'b1;
    ok = 1'b0;
    tries = 0;
    while (!ok) begin
      if (bp_on) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      tries++;
      if (tries > 1000) begin
        $display("FAIL send_timeout at cycle %0d: got=in_ready_low exp=accept", cyc);
        $fatal(1, "input never accepted");
      end
    end
    in_valid = 1'b0;
    cur_lit_en = 1'b0;
  endtask

  task automatic sw_send(input logic [127:0] a, input logic [127:0] b, input logic cin,
                         input logic sub);
    sw_a = a; sw_b = b; sw_cin = cin; sw_sub = sub;
    sw_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] ra, rb;
    rst = 1'b1;
    in_valid = 1'b1; in_a = 64'hDEAD_BEEF_0123_4567; in_b = 64'h1111_2222_3333_4444;
    in_cin = 1'b1; in_sub = 1'b0; out_ready = 1'b1;
    sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_valid = 1'b0; sw_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(10);

    // Directed vectors with hand-computed results {sum, cout, ovf, zero}
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b1,
         {64'd0, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1});
    send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 1'b1,
         {64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0});
    send(64'd3, 64'd5, 1'b1, 1'b1, 1'b1,
         {64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0});
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1,
         {64'd0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0});
    send(64'd5, 64'd5, 1'b0, 1'b1, 1'b1,
         {64'd0, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 1'b1});
    send(64'h1234, 64'h0001, 1'b1, 1'b0, 1'b1,
         {64'd0, 64'h0000_0000_0000_1236, 1'b0, 1'b0, 1'b0});
    idle(10);

    for (int i = 0; i < 100; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, '0);
    idle(12);

    bp_on = 1'b1;
    for (int i = 0; i < 20; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b0, '0);
    bp_on = 1'b0;
    out_ready = 1'b1;
    idle(20);

    // Reset while beats are in flight: nothing may emerge afterwards
    for (int i = 0; i < 3; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, '0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(12);

    for (int k = 0; k < 64; k++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      ra[1:0] = k[1:0];
      rb[1:0] = k[3:2];
      sw_send(ra, rb, k[4], k[5]);
    end
    sw_send({128{1'b1}}, 128'd0, 1'b1, 1'b0);
    sw_send({1'b1, 127'd0}, 128'd1, 1'b0, 1'b1);
    sw_send(128'd0, 128'd0, 1'b0, 1'b0);
    sw_send({128{1'b1}}, {128{1'b1}}, 1'b0, 1'b1);
    sw_valid = 1'b0;
    idle(15);

    fin_req = 1'b1;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
